alu: RTL and testbench

// 32-bit integer ALU for the datapath, selected by a 5-bit opcode.

---
 rtl/alu.sv | 121 ++++++++++++
 tb/tb_alu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 32-bit integer ALU with a single registered result stage (Z_lo / Z_hi).
// Optional status flags are enabled with `define ALU_FLAGS_EN.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       operation,
    output logic [WIDTH-1:0] Z_lo,
    output logic [WIDTH-1:0] Z_hi
`ifdef ALU_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_SHR  = 5'b00101,
        OP_SHRA = 5'b00110,
        OP_SHL  = 5'b00111,
        OP_ROR  = 5'b01000,
        OP_ROL  = 5'b01001,
        OP_AND  = 5'b01010,
        OP_OR   = 5'b01011,
        OP_MUL  = 5'b01111,
        OP_DIV  = 5'b10000,
        OP_NEG  = 5'b10001,
        OP_NOT  = 5'b10010
    } opcode_e;

    logic [4:0]               shamt;
    logic [5:0]               rot_comp;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic                     div_zero;
    logic                     div_ovf;
    logic signed [WIDTH-1:0]  div_b;
    logic signed [WIDTH-1:0]  quo;
    logic signed [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]         lo_d;
    logic [WIDTH-1:0]         hi_d;

    assign shamt    = B[4:0];
    assign rot_comp = 6'(WIDTH) - {1'b0, shamt};

    // Full-width sign extension keeps the low 2*WIDTH bits of the product exact.
    assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    assign prod  = a_ext * b_ext;

    // The two special divide cases are steered away from the divider entirely.
    assign div_zero = (B == '0);
    assign div_ovf  = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
    assign div_b    = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : $signed(B);
    assign quo      = $signed(A) / div_b;
    assign rem      = $signed(A) % div_b;

    always_comb begin
        lo_d = '0;
        hi_d = '0;
        case (operation)
            OP_ADD:  lo_d = A + B;
            OP_SUB:  lo_d = A - B;
            OP_SHR:  lo_d = A >> shamt;
            OP_SHRA: lo_d = $signed(A) >>> shamt;
            OP_SHL:  lo_d = A << shamt;
            OP_ROR:  lo_d = (A >> shamt) | (A << rot_comp);
            OP_ROL:  lo_d = (A << shamt) | (A >> rot_comp);
            OP_AND:  lo_d = A & B;
            OP_OR:   lo_d = A | B;
            OP_MUL: begin
                lo_d = prod[WIDTH-1:0];
                hi_d = prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (div_zero) begin
                    lo_d = '1;
                    hi_d = A;
                end else if (div_ovf) begin
                    lo_d = A;
                    hi_d = '0;
                end else begin
                    lo_d = quo;
                    hi_d = rem;
                end
            end
            OP_NEG:  lo_d = -A;
            OP_NOT:  lo_d = ~A;
            default: begin
                lo_d = '0;
                hi_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Z_lo <= '0;
            Z_hi <= '0;
        end else begin
            Z_lo <= lo_d;
            Z_hi <= hi_d;
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags <= '0;
        end else begin
            flags <= {(operation == OP_DIV) && div_zero, lo_d[WIDTH-1], lo_d == '0};
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/latency sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        reset_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  operation;
    logic [31:0] Z_lo;
    logic [31:0] Z_hi;
`ifdef ALU_FLAGS_EN
    logic [2:0]  flags;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .A         (A),
        .B         (B),
        .operation (operation),
        .Z_lo      (Z_lo),
`ifdef ALU_FLAGS_EN
        .flags     (flags),
`endif
        .Z_hi      (Z_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference built from plain integer arithmetic: shifts as powers of two,
    // rotates as quotient/remainder recombination, divide on 64-bit integers.
    function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
        longint ua  = longint'(a);
        longint ub  = longint'(b);
        longint sa  = longint'($signed(a));
        longint sb  = longint'($signed(b));
        longint m32 = 64'h1_0000_0000;
        longint p   = 1;
        longint q;
        int     s   = int'(b % 32);
        repeat (s) p = p * 2;
        lo = '0;
        hi = '0;
        case (op)
            5'd3:  lo = 32'(ua + ub);
            5'd4:  lo = 32'(ua - ub);
            5'd5:  lo = 32'(ua / p);
            5'd6: begin
                q = sa / p;
                if (sa < 0 && (sa % p) != 0) q = q - 1;
                lo = 32'(q);
            end
            5'd7:  lo = 32'(ua * p);
            5'd8:  lo = 32'(ua / p + (ua % p) * (m32 / p));
            5'd9:  lo = 32'((ua * p) % m32 + (ua * p) / m32);
            5'd10: lo = a & b;
            5'd11: lo = a | b;
            5'd15: begin
                q  = sa * sb;
                lo = 32'(q);
                hi = 32'(q / m32 - ((q % m32) < 0 ? 1 : 0));
            end
            5'd16: begin
                if (ub == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end
            end
            5'd17: lo = 32'(-sa);
            5'd18: lo = ~a;
            default: ;
        endcase
    endfunction

    task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        operation = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[$];
    logic [4:0]  valid_ops[13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                   5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic [31:0] prev_lo;
    logic [4:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        A         = 32'h1234_5678;
        B         = 32'h9;
        operation = 5'b00011;
        #1;
        check("reset_lo", Z_lo, 32'h0);
        check("reset_hi", Z_hi, 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold_lo", Z_lo, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        vecs.push_back('{5'b00011, 32'd5,          32'd3,          32'd8,          32'd0});
        vecs.push_back('{5'b00100, 32'd10,         32'd3,          32'd7,          32'd0});
        vecs.push_back('{5'b01010, 32'd12,         32'd5,          32'd4,          32'd0});
        vecs.push_back('{5'b01011, 32'd12,         32'd5,          32'd13,         32'd0});
        vecs.push_back('{5'b01111, 32'd6,          32'd3,          32'd18,         32'd0});
        vecs.push_back('{5'b01111, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA,  32'hFFFF_FFFF});
        vecs.push_back('{5'b10000, 32'd10,         32'd2,          32'd5,          32'd0});
        vecs.push_back('{5'b10000, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF});
        vecs.push_back('{5'b10000, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234});
        vecs.push_back('{5'b10000, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0});
        vecs.push_back('{5'b00110, 32'd8,          32'd2,          32'd2,          32'd0});
        vecs.push_back('{5'b00110, 32'h8000_0000,  32'd2,          32'hE000_0000,  32'd0});
        vecs.push_back('{5'b00111, 32'd1,          32'd2,          32'd4,          32'd0});
        vecs.push_back('{5'b01000, 32'd1,          32'd2,          32'h4000_0000,  32'd0});
        vecs.push_back('{5'b01001, 32'd128,        32'd2,          32'd512,        32'd0});
        vecs.push_back('{5'b00101, 32'h8000_0000,  32'd4,          32'h0800_0000,  32'd0});
        vecs.push_back('{5'b00111, 32'h1234_5678,  32'h20,         32'h1234_5678,  32'd0});
        vecs.push_back('{5'b01000, 32'h1234_5678,  32'hFFFF_FFE0,  32'h1234_5678,  32'd0});
        vecs.push_back('{5'b01001, 32'h8000_0001,  32'd1,          32'h0000_0003,  32'd0});
        vecs.push_back('{5'b10001, 32'd10,         32'd0,          32'hFFFF_FFF6,  32'd0});
        vecs.push_back('{5'b10001, 32'h8000_0000,  32'd0,          32'h8000_0000,  32'd0});
        vecs.push_back('{5'b10010, 32'd10,         32'd0,          32'hFFFF_FFF5,  32'd0});
        vecs.push_back('{5'b11111, 32'd10,         32'd7,          32'd0,          32'd0});
        vecs.push_back('{5'b00000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd0});

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_lo", i), Z_lo, vecs[i].lo);
            check($sformatf("vec%0d_hi", i), Z_hi, vecs[i].hi);
        end

        // Back-to-back ADD/SUB: old result must hold until the edge, new one after it.
        prev_lo = Z_lo;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            operation = (i % 2 == 0) ? 5'b00011 : 5'b00100;
            A = $urandom;
            B = $urandom;
            model(operation, A, B, exp_lo, exp_hi);
            #1;
            check($sformatf("stream%0d_hold", i), Z_lo, prev_lo);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d_lo", i), Z_lo, exp_lo);
            prev_lo = exp_lo;
        end

        // Asynchronous reset mid-cycle with a non-zero result held.
        apply(5'b01111, 32'hFFFF_FFFE, 32'd3);
        check("pre_rst_lo", Z_lo, 32'hFFFF_FFFA);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_lo", Z_lo, 32'h0);
        check("async_rst_hi", Z_hi, 32'h0);
        @(posedge clk);
        #1;
        check("rst_edge_lo", Z_lo, 32'h0);
        check("rst_edge_hi", Z_hi, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_release_lo", Z_lo, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_lo", Z_lo, 32'hFFFF_FFFA);
        check("post_rst_hi", Z_hi, 32'hFFFF_FFFF);

        for (int i = 0; i < 400; i++) begin
            rop = ($urandom_range(0, 9) < 8) ? valid_ops[$urandom_range(0, 12)]
                                             : 5'($urandom_range(0, 31));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(0, 40));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = -32'($urandom_range(1, 9));
                4: ra = -32'($urandom_range(0, 1000));
                default: ;
            endcase
            model(rop, ra, rb, exp_lo, exp_hi);
            apply(rop, ra, rb);
            check($sformatf("rnd%0d_op%0d_lo", i, rop), Z_lo, exp_lo);
            check($sformatf("rnd%0d_op%0d_hi", i, rop), Z_hi, exp_hi);
`ifdef ALU_FLAGS_EN
            check($sformatf("rnd%0d_flags", i), {29'd0, flags},
                  {29'd0, (rop == 5'd16) && (rb == 32'd0), exp_lo[31], exp_lo == 32'd0});
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
